// File: rtl/arb_pkg.sv
// Shared types for the SRAM-like port arbiter: FSM states, owner encoding,
// the grant bundle and the default anti-starvation limit.
package arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      WAIT = 2'd2
   } arbState_t;

   typedef enum logic {
      OWN_INST = 1'b0,
      OWN_DATA = 1'b1
   } owner_t;

   typedef struct packed {
      logic instWin;
      logic dataWin;
   } grant_t;

   localparam int DEFAULT_STARVE_LIMIT = 4;

endpackage

// File: rtl/sram_like_arbiter.sv
// Shares one SRAM-like memory port between the instruction-fetch and data
// requesters: one outstanding transaction, data-first with an inst starvation guard.
module sram_like_arbiter
   import arb_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                inst_req,
   input  logic [ADDR_W-1:0]   inst_addr,
   output logic                inst_addr_ok,
   output logic                inst_data_ok,
   output logic [DATA_W-1:0]   inst_rdata,
   input  logic                data_req,
   input  logic                data_wr,
   input  logic [DATA_W/8-1:0] data_wstrb,
   input  logic [ADDR_W-1:0]   data_addr,
   input  logic [DATA_W-1:0]   data_wdata,
   output logic                data_addr_ok,
   output logic                data_data_ok,
   output logic [DATA_W-1:0]   data_rdata,
   output logic                mem_req,
   output logic                mem_wr,
   output logic [DATA_W/8-1:0] mem_wstrb,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic                mem_addr_ok,
   input  logic                mem_data_ok,
   input  logic [DATA_W-1:0]   mem_rdata
);

   localparam int STRB_W = DATA_W / 8;
   localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

   arbState_t          stateReg;
   arbState_t          stateNext;
   owner_t             ownerReg;
   logic [CNT_W-1:0]   starveCntReg;
   grant_t             grant;
   logic               anyGrant;
   logic               complete;

   logic               memReqReg;
   logic               memWrReg;
   logic [STRB_W-1:0]  memWstrbReg;
   logic [ADDR_W-1:0]  memAddrReg;
   logic [DATA_W-1:0]  memWdataReg;
   logic [DATA_W-1:0]  instRdataReg;
   logic [DATA_W-1:0]  dataRdataReg;
   logic               instDataOkReg;
   logic               dataDataOkReg;

   // Data wins by default; inst wins when alone or once data has starved it.
   function automatic grant_t pickGrant(input logic instReq,
                                        input logic dataReq,
                                        input logic starved);
      grant_t g;
      g.instWin = instReq && (!dataReq || starved);
      g.dataWin = dataReq && !g.instWin;
      return g;
   endfunction

   always_comb begin
      grant = pickGrant(inst_req, data_req, starveCntReg == STARVE_MAX);
      if (stateReg != IDLE) begin
         grant = '0;
      end
   end

   assign anyGrant     = grant.instWin || grant.dataWin;
   assign inst_addr_ok = grant.instWin;
   assign data_addr_ok = grant.dataWin;

   // A response that lands together with the address handshake finishes the transfer too.
   assign complete = ((stateReg == ADDR) && mem_addr_ok && mem_data_ok) ||
                     ((stateReg == WAIT) && mem_data_ok);

   always_comb begin
      stateNext = stateReg;
      case (stateReg)
         IDLE: begin
            if (anyGrant) begin
               stateNext = ADDR;
            end
         end
         ADDR: begin
            if (mem_addr_ok) begin
               stateNext = mem_data_ok ? IDLE : WAIT;
            end
         end
         WAIT: begin
            if (mem_data_ok) begin
               stateNext = IDLE;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stateReg <= IDLE;
         ownerReg <= OWN_INST;
      end else begin
         stateReg <= stateNext;
         if (anyGrant) begin
            ownerReg <= grant.dataWin ? OWN_DATA : OWN_INST;
         end
      end
   end

   // Counts data grants made over a waiting inst request.
   always_ff @(posedge clk) begin
      if (reset) begin
         starveCntReg <= '0;
      end else if (stateReg == IDLE) begin
         if (grant.instWin || !inst_req) begin
            starveCntReg <= '0;
         end else if (grant.dataWin) begin
            starveCntReg <= starveCntReg + CNT_W'(1);
         end
      end
   end

   // Command registers stay frozen from grant until the memory accepts.
   always_ff @(posedge clk) begin
      if (reset) begin
         memReqReg   <= 1'b0;
         memWrReg    <= 1'b0;
         memWstrbReg <= '0;
         memAddrReg  <= '0;
         memWdataReg <= '0;
      end else if (anyGrant) begin
         memReqReg <= 1'b1;
         if (grant.dataWin) begin
            memWrReg    <= data_wr;
            memWstrbReg <= data_wstrb;
            memAddrReg  <= data_addr;
            memWdataReg <= data_wdata;
         end else begin
            memWrReg    <= 1'b0;
            memWstrbReg <= '0;
            memAddrReg  <= inst_addr;
            memWdataReg <= '0;
         end
      end else if ((stateReg == ADDR) && mem_addr_ok) begin
         memReqReg <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         instRdataReg  <= '0;
         dataRdataReg  <= '0;
         instDataOkReg <= 1'b0;
         dataDataOkReg <= 1'b0;
      end else begin
         instDataOkReg <= complete && (ownerReg == OWN_INST);
         dataDataOkReg <= complete && (ownerReg == OWN_DATA);
         if (complete && (ownerReg == OWN_INST)) begin
            instRdataReg <= mem_rdata;
         end
         if (complete && (ownerReg == OWN_DATA)) begin
            dataRdataReg <= mem_rdata;
         end
      end
   end

   assign inst_data_ok = instDataOkReg;
   assign inst_rdata   = instRdataReg;
   assign data_data_ok = dataDataOkReg;
   assign data_rdata   = dataRdataReg;
   assign mem_req      = memReqReg;
   assign mem_wr       = memWrReg;
   assign mem_wstrb    = memWstrbReg;
   assign mem_addr     = memAddrReg;
   assign mem_wdata    = memWdataReg;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Randomized bench for sram_like_arbiter: the bench acts as both requesters and
// the memory, predicting every handshake from a per-transaction cycle timeline.
module tb_sram_like_arbiter;
   import arb_pkg::*;

   localparam int ADDR_W     = 32;
   localparam int DATA_W     = 32;
   localparam int STRB_W     = DATA_W / 8;
   localparam int LIMIT      = 4;
   localparam int NUM_CYCLES = 4000;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              inst_req = 1'b0;
   logic [ADDR_W-1:0] inst_addr = '0;
   logic              inst_addr_ok;
   logic              inst_data_ok;
   logic [DATA_W-1:0] inst_rdata;
   logic              data_req = 1'b0;
   logic              data_wr = 1'b0;
   logic [STRB_W-1:0] data_wstrb = '0;
   logic [ADDR_W-1:0] data_addr = '0;
   logic [DATA_W-1:0] data_wdata = '0;
   logic              data_addr_ok;
   logic              data_data_ok;
   logic [DATA_W-1:0] data_rdata;
   logic              mem_req;
   logic              mem_wr;
   logic [STRB_W-1:0] mem_wstrb;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_addr_ok = 1'b0;
   logic              mem_data_ok = 1'b0;
   logic [DATA_W-1:0] mem_rdata = '0;

   sram_like_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT)
   ) dut (
      .clk(clk), .reset(reset),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
      .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
      .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
      .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   int errCount   = 0;
   int checkCount = 0;
   int cycleNum   = 0;

   task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checkCount++;
      if (got !== exp) begin
         errCount++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cycleNum);
      end
   endtask

   // Current transaction timeline, all in absolute cycle numbers.
   int freeAt, acceptAt, dataAt, respAt;
   bit ownData;
   logic [ADDR_W-1:0] tAddr;
   logic              tWr;
   logic [STRB_W-1:0] tWstrb;
   logic [DATA_W-1:0] tWdata;

   // Pending requester commands.
   bit instPend, dataPend;
   logic [ADDR_W-1:0] iAddr, dAddr;
   logic              dWr;
   logic [STRB_W-1:0] dStrb;
   logic [DATA_W-1:0] dWdata;

   logic [DATA_W-1:0] expIRdata, expDRdata, memRdataVal;
   int  starve, resetsDone, txnNum, pI, pD;
   bit  free, postRst, lateDataOk, doRst, grantI, grantD, expReq;

   initial begin
      freeAt = 0; acceptAt = -1; dataAt = -1; respAt = -1; ownData = 0;
      tAddr = '0; tWr = 0; tWstrb = '0; tWdata = '0;
      instPend = 0; dataPend = 0;
      expIRdata = '0; expDRdata = '0; starve = 0;
      resetsDone = 0; txnNum = 0; postRst = 1; lateDataOk = 0;
      repeat (2) @(posedge clk);

      for (int t = 0; t < NUM_CYCLES; t++) begin
         @(negedge clk);
         cycleNum = t;
         free = (t >= freeAt);

         // Occasionally reset while the memory is still owing data.
         doRst = !free && (t > acceptAt) && (t < dataAt) &&
                 (($urandom_range(0, 15) == 0) || ((t > 2500) && (resetsDone == 0)));
         if (doRst) begin
            reset = 1; inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 0;
            instPend = 0; dataPend = 0; resetsDone++;
            freeAt = t + 1; acceptAt = -1; dataAt = -1; respAt = -1;
            expIRdata = '0; expDRdata = '0; starve = 0;
            postRst = 1; lateDataOk = 1;
            $display("cycle %0d: reset during WAIT", t);
            continue;
         end
         reset = 0;

         pI = (t >= 1200 && t < 2000) ? 100 : 45;
         pD = (t >= 1200 && t < 2000) ? 100 : 40;
         if (!instPend && !postRst && ($urandom_range(1, 100) <= pI)) begin
            instPend = 1; iAddr = $urandom;
         end
         if (!dataPend && !postRst && ($urandom_range(1, 100) <= pD)) begin
            dataPend = 1; dWr = 1'($urandom_range(0, 1));
            dStrb = dWr ? STRB_W'($urandom) : '0;
            dAddr = $urandom; dWdata = $urandom;
         end
         inst_req   = instPend;
         inst_addr  = instPend ? iAddr : $urandom;
         data_req   = dataPend;
         data_wr    = dataPend ? dWr : 1'($urandom_range(0, 1));
         data_wstrb = dataPend ? dStrb : STRB_W'($urandom);
         data_addr  = dataPend ? dAddr : $urandom;
         data_wdata = dataPend ? dWdata : $urandom;

         // Memory side, with stray handshakes wherever they must be ignored.
         mem_addr_ok = !free && (t == acceptAt);
         mem_data_ok = (!free && (t == dataAt)) || lateDataOk;
         if (!mem_addr_ok && (free || t > acceptAt) && ($urandom_range(0, 3) == 0))
            mem_addr_ok = 1;
         if (!mem_data_ok && (free || t < acceptAt) && ($urandom_range(0, 3) == 0))
            mem_data_ok = 1;
         memRdataVal = $urandom;
         mem_rdata   = memRdataVal;
         lateDataOk  = 0;

         #1;
         grantI = free && inst_req && (!data_req || starve == LIMIT);
         grantD = free && data_req && !grantI;
         expReq = !free && (t <= acceptAt);

         checkVal("inst_addr_ok", inst_addr_ok, grantI);
         checkVal("data_addr_ok", data_addr_ok, grantD);
         checkVal("inst_data_ok", inst_data_ok, (t == respAt) && !ownData);
         checkVal("data_data_ok", data_data_ok, (t == respAt) && ownData);
         checkVal("inst_rdata", inst_rdata, expIRdata);
         checkVal("data_rdata", data_rdata, expDRdata);
         checkVal("mem_req", mem_req, expReq);
         if (expReq) begin
            checkVal("mem_addr", mem_addr, tAddr);
            checkVal("mem_wr", mem_wr, tWr);
            checkVal("mem_wstrb", mem_wstrb, tWstrb);
            if (ownData) checkVal("mem_wdata", mem_wdata, tWdata);
         end
         if (postRst) begin
            checkVal("rst_mem_addr", mem_addr, 0);
            checkVal("rst_mem_wr", mem_wr, 0);
            checkVal("rst_mem_wstrb", mem_wstrb, 0);
            checkVal("rst_mem_wdata", mem_wdata, 0);
         end

         if (!free && (t == dataAt)) begin
            if (ownData) expDRdata = memRdataVal;
            else         expIRdata = memRdataVal;
         end
         if (free) begin
            if (grantI || !inst_req) starve = 0;
            else if (grantD)         starve++;
         end
         if (grantI || grantD) begin
            ownData  = grantD;
            acceptAt = t + 1 + $urandom_range(0, 3);
            dataAt   = acceptAt + $urandom_range(0, 3);
            respAt   = dataAt + 1;
            freeAt   = respAt;
            if (grantD) begin
               tAddr = dAddr; tWr = dWr; tWstrb = dStrb; tWdata = dWdata; dataPend = 0;
            end else begin
               tAddr = iAddr; tWr = 0; tWstrb = '0; tWdata = '0; instPend = 0;
            end
            txnNum++;
            $display("txn %0d cycle %0d: %s %s addr=0x%08h accept@%0d data@%0d",
                     txnNum, t, grantD ? "data" : "inst", tWr ? "wr" : "rd",
                     tAddr, acceptAt, dataAt);
         end
         postRst = 0;
      end

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
